// File: rtl/ips_gen.sv
// Poisson-style input spike generator: one M-bit spike vector per advance request,
// pixel i fires when its pseudo-random byte is below its stored 8-bit intensity.
module ips_gen #(
    parameter int          M     = 784,
    parameter int          PW    = 8,
    parameter int          AW    = 10,
    parameter int          T_MAX = 201,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_we,
    input  logic [AW-1:0] pix_addr,
    input  logic [PW-1:0] pix_data,
    input  logic          start_ips_gen,
    input  logic          next_ips_gen,
    output logic [M-1:0]  ips_gen_out,
    output logic          busy,
    output logic          gen_done,
    output logic [8:0]    step_count
);

    localparam int L = M / 2;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         w_done_next;
    logic         w_at_end;
    logic         w_step;
    logic         w_pix_wr;
    logic [M-1:0] w_cmp;

    assign w_at_end = (r_state == S_RUN) && (step_count == 9'(T_MAX));
    // start overrides both the end-of-presentation check and the RUN-only gating of next
    assign w_step   = start_ips_gen ? next_ips_gen
                                    : ((r_state == S_RUN) && !w_at_end && next_ips_gen);
    assign w_pix_wr = pix_we && (r_state == S_IDLE) && (pix_addr < AW'(M));
    assign busy     = (r_state == S_RUN);

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        if (start_ips_gen) begin
            w_state_next = S_RUN;
        end else if (w_at_end) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            gen_done    <= 1'b0;
            step_count  <= 9'd0;
            ips_gen_out <= '0;
        end else begin
            r_state     <= w_state_next;
            gen_done    <= w_done_next;
            ips_gen_out <= w_step ? w_cmp : '0;
            if (start_ips_gen) begin
                step_count <= next_ips_gen ? 9'd1 : 9'd0;
            end else if (w_step) begin
                step_count <= step_count + 9'd1;
            end
        end
    end

    // Each lane owns one LFSR and the two pixels fed by its low and high byte.
    genvar gi;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lane
            localparam logic [15:0] LP_MIX  = SEED ^ 16'((gi * 40503) % 65536);
            localparam logic [15:0] LP_SEED = (LP_MIX == 16'h0000) ? 16'h0001 : LP_MIX;

            logic [15:0]   r_lfsr;
            logic [15:0]   w_src;
            logic [15:0]   w_adv;
            logic [PW-1:0] r_pix_lo;
            logic [PW-1:0] r_pix_hi;

            // On a start cycle the seed itself is the current state, so step 0 can be emitted at once.
            assign w_src = start_ips_gen ? LP_SEED : r_lfsr;
            assign w_adv = {1'b0, w_src[15:1]} ^ (w_src[0] ? 16'hB400 : 16'h0000);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_lfsr <= LP_SEED;
                end else if (w_step) begin
                    r_lfsr <= w_adv;
                end else if (start_ips_gen) begin
                    r_lfsr <= LP_SEED;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pix_lo <= '0;
                    r_pix_hi <= '0;
                end else if (w_pix_wr) begin
                    if (pix_addr == AW'(2 * gi))     r_pix_lo <= pix_data;
                    if (pix_addr == AW'(2 * gi + 1)) r_pix_hi <= pix_data;
                end
            end

            assign w_cmp[2*gi]   = PW'(w_src[7:0])  < r_pix_lo;
            assign w_cmp[2*gi+1] = PW'(w_src[15:8]) < r_pix_hi;
        end
    endgenerate

endmodule

// File: tb/tb_ips_gen.sv
// Directed bench for ips_gen: table-driven control vectors plus hand-written
// full-presentation sequences checked against a behavioural LFSR/compare model.
module tb_ips_gen;

    localparam int          M     = 784;
    localparam int          PW    = 8;
    localparam int          AW    = 10;
    localparam int          T_MAX = 201;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          L     = M / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_we = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic [PW-1:0] pix_data = '0;
    logic          start_ips_gen = 1'b0;
    logic          next_ips_gen = 1'b0;
    logic [M-1:0]  ips_gen_out;
    logic          busy;
    logic          gen_done;
    logic [8:0]    step_count;

    ips_gen #(.M(M), .PW(PW), .AW(AW), .T_MAX(T_MAX), .SEED(SEED)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_we       (pix_we),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .start_ips_gen(start_ips_gen),
        .next_ips_gen (next_ips_gen),
        .ips_gen_out  (ips_gen_out),
        .busy         (busy),
        .gen_done     (gen_done),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   m_pix  [M];
    logic [15:0]  m_lfsr [L];
    logic [M-1:0] cur_seq [T_MAX];
    logic [M-1:0] seq_a   [T_MAX];

    typedef struct {
        bit start;
        bit nxt;
        bit we;
        int addr;
        int data;
        int exp_step;
        bit exp_busy;
        bit exp_vec;
    } vec_t;

    vec_t tbl [8];

    function automatic logic [15:0] seed_of(input int k);
        logic [15:0] s;
        s = SEED ^ 16'((k * 40503) & 32'h0000FFFF);
        if (s == 16'h0000) s = 16'h0001;
        return s;
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic model_reseed();
        for (int k = 0; k < L; k++) m_lfsr[k] = seed_of(k);
    endtask

    task automatic model_emit(output logic [M-1:0] v);
        v = '0;
        for (int k = 0; k < L; k++) begin
            v[2*k]   = m_lfsr[k][7:0]  < m_pix[2*k];
            v[2*k+1] = m_lfsr[k][15:8] < m_pix[2*k+1];
            m_lfsr[k] = lfsr_adv(m_lfsr[k]);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        int first;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            first = -1;
            for (int i = M - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
            $display("FAIL %s: bit %0d got %b want %b (ones got %0d want %0d)",
                     name, first, act[first], exp[first], $countones(act), $countones(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pix(input int a, input int d, input bit upd_model);
        pix_we   = 1'b1;
        pix_addr = AW'(a);
        pix_data = PW'(d);
        tick();
        pix_we = 1'b0;
        if (upd_model) m_pix[a] = 8'(d);
    endtask

    // Full presentation: start+next together, next held for T_MAX cycles, then completion.
    task automatic run_pres(input string tag);
        logic [M-1:0] exp;
        model_reseed();
        start_ips_gen = 1'b1;
        next_ips_gen  = 1'b1;
        for (int s = 0; s < T_MAX; s++) begin
            model_emit(exp);
            tick();
            start_ips_gen = 1'b0;
            cur_seq[s] = ips_gen_out;
            chk_vec($sformatf("%s v%0d", tag, s), ips_gen_out, exp);
            if (s == 0) chk({tag, " step after start"}, 32'(step_count), 32'd1);
        end
        chk({tag, " step at end"}, 32'(step_count), 32'(T_MAX));
        chk({tag, " busy at end"}, 32'(busy), 32'd1);
        chk({tag, " done early"}, 32'(gen_done), 32'd0);
        tick();
        chk({tag, " done pulse"}, 32'(gen_done), 32'd1);
        chk({tag, " busy fall"}, 32'(busy), 32'd0);
        chk({tag, " out zero at done"}, 32'(ips_gen_out == '0), 32'd1);
        chk({tag, " step holds"}, 32'(step_count), 32'(T_MAX));
        next_ips_gen = 1'b0;
        tick();
        chk({tag, " done one cycle"}, 32'(gen_done), 32'd0);
    endtask

    initial begin
        logic [M-1:0] exp;
        logic [M-1:0] mask;
        int c0, c1, c2, m2, ones, ndiff;
        logic [15:0] x;

        for (int i = 0; i < M; i++) m_pix[i] = 8'd0;

        // Reset state
        #1;
        chk("rst out", 32'(ips_gen_out == '0), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(gen_done), 32'd0);
        chk("rst step", 32'(step_count), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // All-zero image
        run_pres("zero");
        ones = 0;
        for (int s = 0; s < T_MAX; s++) ones += $countones(cur_seq[s]);
        chk("zero total ones", 32'(ones), 32'd0);

        // Image: pixel0=255, pixel1=0, rest 128
        for (int i = 0; i < M; i++) write_pix(i, (i == 0) ? 255 : (i == 1) ? 0 : 128, 1'b1);
        run_pres("img");
        c0 = 0; c1 = 0; c2 = 0;
        for (int s = 0; s < T_MAX; s++) begin
            c0 += int'(cur_seq[s][0]);
            c1 += int'(cur_seq[s][1]);
            c2 += int'(cur_seq[s][2]);
        end
        x  = seed_of(1);
        m2 = 0;
        for (int s = 0; s < T_MAX; s++) begin
            if (x[7:0] < 8'd128) m2++;
            x = lfsr_adv(x);
        end
        chk("bit1 never", 32'(c1), 32'd0);
        chk("bit0 in 195..201", 32'((c0 >= 195) && (c0 <= 201)), 32'd1);
        chk("bit2 golden count", 32'(c2), 32'(m2));

        // Control table: IDLE next ignored, start w/o next, toggled next, ignored writes
        tbl[0] = '{0, 1, 1, 800, 255, T_MAX, 0, 0};
        tbl[1] = '{1, 0, 0, 0,   0,   0,     1, 0};
        tbl[2] = '{0, 1, 0, 0,   0,   1,     1, 1};
        tbl[3] = '{0, 0, 0, 0,   0,   1,     1, 0};
        tbl[4] = '{0, 1, 0, 0,   0,   2,     1, 1};
        tbl[5] = '{0, 0, 0, 0,   0,   2,     1, 0};
        tbl[6] = '{0, 0, 1, 5,   255, 2,     1, 0};
        tbl[7] = '{0, 1, 0, 0,   0,   3,     1, 1};
        for (int r = 0; r < 8; r++) begin
            start_ips_gen = tbl[r].start;
            next_ips_gen  = tbl[r].nxt;
            pix_we        = tbl[r].we;
            pix_addr      = AW'(tbl[r].addr);
            pix_data      = PW'(tbl[r].data);
            if (tbl[r].start) model_reseed();
            if (tbl[r].exp_vec) model_emit(exp);
            else exp = '0;
            tick();
            chk($sformatf("tbl%0d step", r), 32'(step_count), 32'(tbl[r].exp_step));
            chk($sformatf("tbl%0d busy", r), 32'(busy), 32'(tbl[r].exp_busy));
            chk($sformatf("tbl%0d done", r), 32'(gen_done), 32'd0);
            chk_vec($sformatf("tbl%0d vec", r), ips_gen_out, exp);
        end
        start_ips_gen = 1'b0;
        pix_we        = 1'b0;

        // Advance to step 50, then restart mid-run; run also exposes any ignored-write leak
        next_ips_gen = 1'b1;
        for (int s = 3; s < 50; s++) begin
            model_emit(exp);
            tick();
            chk_vec($sformatf("pre-restart v%0d", s), ips_gen_out, exp);
        end
        chk("step before restart", 32'(step_count), 32'd50);
        run_pres("restart");

        // Determinism, then single-pixel change
        run_pres("repA");
        for (int s = 0; s < T_MAX; s++) seq_a[s] = cur_seq[s];
        run_pres("repB");
        ndiff = 0;
        for (int s = 0; s < T_MAX; s++) if (cur_seq[s] !== seq_a[s]) ndiff++;
        chk("repeat identical", 32'(ndiff), 32'd0);
        write_pix(3, 10, 1'b1);
        run_pres("pix3");
        mask = '0;
        for (int s = 0; s < T_MAX; s++) mask |= (cur_seq[s] ^ seq_a[s]);
        chk("pix3 bit differs", 32'(mask[3]), 32'd1);
        mask[3] = 1'b0;
        chk("others unchanged", 32'(mask == '0), 32'd1);

        // Asynchronous reset mid-run
        start_ips_gen = 1'b1;
        next_ips_gen  = 1'b1;
        tick();
        start_ips_gen = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst out", 32'(ips_gen_out == '0), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst step", 32'(step_count), 32'd0);
        next_ips_gen = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < M; i++) m_pix[i] = 8'd0;
        tick();
        run_pres("post-rst");
        ones = 0;
        for (int s = 0; s < T_MAX; s++) ones += $countones(cur_seq[s]);
        chk("post-rst total ones", 32'(ones), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
